signed_divider_32by16: RTL and testbench
========================================

# signed_divider_32by16

Sequential signed divider: a 32-bit two's-complement dividend divided by a 16-bit two's-complement divisor, producing a 32-bit quotient and a 16-bit remainder. It is the inverse path of the 16x16 signed array multiplier. It sits after the convolution MAC stage to normalise 32-bit accumulations back down by a kernel weight sum. It is a radix-2 restoring divider operating on magnitudes, one quotient bit per cycle, with valid/ready handshakes on both sides.

## Interface
- No parameters; widths are fixed at 32/16 to match the multiplier output and operand widths.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  dividend/divisor valid
- in_ready  output  1  block can accept an operation
- dividend  input  32  signed dividend, sampled on accept
- divisor  input  16  signed divisor, sampled on accept
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  32  signed quotient, truncated toward zero
- remainder  output  16  signed remainder, sign follows dividend
- div_by_zero  output  1  divisor was 0
- overflow  output  1  dividend = 32'h80000000 and divisor = -1

## Operation
- States:
  - IDLE: in_ready = 1.
  - BUSY: 32 iterations, 5-bit counter.
  - FIX: sign correction and special cases.
  - DONE: out_valid = 1.
- Accept occurs when in_valid & in_ready on an edge:
  - Register |dividend| (32-bit unsigned) and |divisor| (16-bit unsigned; |-32768| = 16'h8000).
  - Register both sign bits.
  - Clear the 17-bit partial remainder; load the counter with 31; go to BUSY.
- BUSY iteration (one per edge, MSB first):
  - pr = {pr[15:0], dq[31]}.
  - If pr >= |divisor|: pr -= |divisor| and shift 1 into the quotient; else shift 0.
  - Leave BUSY after the iteration with counter = 0.
- FIX (one edge):
  - quotient = sign_a ^ sign_b ? -q : q.
  - remainder = sign_a ? -pr[15:0] : pr[15:0].
  - Overrides apply, in priority order:
    - div_by_zero: quotient = sign_a ? 32'h80000000 : 32'h7FFFFFFF; remainder = dividend[15:0]; div_by_zero = 1.
    - overflow: quotient = 32'h7FFFFFFF; remainder = 0; overflow = 1.
  - Go to DONE.
- DONE:
  - Hold quotient, remainder and flags stable until out_valid & out_ready, then go to IDLE.
  - Flags are valid only while out_valid = 1.
- Invariants for non-special cases:
  - dividend = quotient*divisor + remainder.
  - |remainder| < |divisor|.
  - remainder is 0 or has the dividend's sign.
- Inputs are ignored outside IDLE (in_ready = 0). dividend/divisor need not stay stable after accept.

## Timing
- Reset (edge with rst = 1): state IDLE, in_ready = 1, out_valid = 0, quotient = 0, remainder = 0, div_by_zero = 0, overflow = 0.
- rst takes priority over every other event, including mid-BUSY and DONE. Any in-flight result is discarded with no out_valid pulse.
- Latency is fixed for all operands, including special cases:
  - Accept on edge T; BUSY across edges T+1..T+32; FIX result registered at edge T+33.
  - out_valid = 1 in the cycle following edge T+33.
- Throughput: at most one operation per 35 cycles. The DONE→IDLE handoff edge and the next accept edge are distinct, so there is no accept in the same cycle as result retirement.
- in_ready is a registered function of state (IDLE only). out_valid is registered (DONE only).
- Back-pressure: out_ready low holds DONE indefinitely, with outputs unchanged.

## Test plan
- Positive divide: dividend 100000, divisor 7 → at 33 cycles after accept, quotient 14285 (32'h000037CD), remainder 5, flags 0.
- Mixed signs: dividend -100000, divisor 7 → quotient 32'hFFFFC833 (-14285), remainder 16'hFFFB (-5). Also dividend 32'h7FFFFFFF, divisor -32768 → quotient 32'hFFFF0001, remainder 16'h7FFF.
- Special cases:
  - 1234 / 0 → quotient 32'h7FFFFFFF, remainder 16'h04D2, div_by_zero 1.
  - -5 / 0 → quotient 32'h80000000.
  - 32'h80000000 / -1 → quotient 32'h7FFFFFFF, remainder 0, overflow 1, div_by_zero 0.
- Back-pressure: out_ready low for 10 cycles after out_valid → outputs stable, in_ready 0. Pulse in_valid during this window → no accept. Raise out_ready → IDLE next cycle, in_ready 1.
- Reset mid-operation: assert rst 10 cycles after accept → next cycle IDLE, all outputs at reset values, no out_valid. A subsequent 100000/7 completes correctly.
- Randomised back-to-back: 1000 random operand pairs with random out_ready stalls → every result matches the truncating reference model; latency is always 33 cycles.

Source files
------------

// File: rtl/signed_divider_32by16.sv
// -----------------------------------------------------------------------------
// signed_divider_32by16
//   Sequential signed divider, 32-bit dividend / 16-bit divisor.
//   Radix-2 restoring division on magnitudes, one quotient bit per cycle,
//   followed by a single sign-fix cycle. Latency is fixed at 33 cycles from
//   accept to registered result, including the divide-by-zero and overflow
//   special cases.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     operands valid
//   in_ready     block idle, will accept on in_valid
//   dividend     signed 32-bit dividend (sampled on accept)
//   divisor      signed 16-bit divisor  (sampled on accept)
//   out_valid    result valid, held until out_ready
//   out_ready    consumer takes result
//   quotient     signed quotient, truncated toward zero
//   remainder    signed remainder, sign follows dividend
//   div_by_zero  divisor was zero
//   overflow     dividend = -2^31 and divisor = -1
// -----------------------------------------------------------------------------
module signed_divider_32by16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] dividend,
   input  logic [15:0] divisor,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] quotient,
   output logic [15:0] remainder,
   output logic        div_by_zero,
   output logic        overflow
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] dq_q, dq_d;       // dividend magnitude, becomes quotient magnitude
   logic [15:0] dv_q, dv_d;       // divisor magnitude
   logic [16:0] pr_q, pr_d;       // partial remainder
   logic [4:0]  cnt_q, cnt_d;
   logic        sign_a_q, sign_a_d;
   logic        sign_b_q, sign_b_d;
   logic        dbz_pend_q, dbz_pend_d;
   logic        ovf_pend_q, ovf_pend_d;
   logic [15:0] lo_q, lo_d;       // raw dividend[15:0] for the div-by-zero remainder
   logic [31:0] quot_q, quot_d;
   logic [15:0] rem_q, rem_d;
   logic        dbz_q, dbz_d;
   logic        ovf_q, ovf_d;
   logic        in_ready_q, in_ready_d;
   logic        out_valid_q, out_valid_d;

   logic [16:0] pr_sh;
   logic [16:0] pr_sub;

   // pr_q < |divisor| <= 2^15, so the shifted value always fits in 17 bits.
   assign pr_sh  = {pr_q[15:0], dq_q[31]};
   assign pr_sub = pr_sh - {1'b0, dv_q};

   always_comb begin
      state_d     = state_q;
      dq_d        = dq_q;
      dv_d        = dv_q;
      pr_d        = pr_q;
      cnt_d       = cnt_q;
      sign_a_d    = sign_a_q;
      sign_b_d    = sign_b_q;
      dbz_pend_d  = dbz_pend_q;
      ovf_pend_d  = ovf_pend_q;
      lo_d        = lo_q;
      quot_d      = quot_q;
      rem_d       = rem_q;
      dbz_d       = dbz_q;
      ovf_d       = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               // -(-2^31) wraps to 32'h80000000, which is the correct magnitude
               dq_d       = dividend[31] ? -dividend : dividend;
               dv_d       = divisor[15]  ? -divisor  : divisor;
               sign_a_d   = dividend[31];
               sign_b_d   = divisor[15];
               dbz_pend_d = (divisor == 16'h0000);
               ovf_pend_d = (dividend == 32'h8000_0000) && (divisor == 16'hFFFF);
               lo_d       = dividend[15:0];
               pr_d       = '0;
               cnt_d      = 5'd31;
               state_d    = S_BUSY;
            end
         end
         S_BUSY: begin
            if (pr_sh >= {1'b0, dv_q}) begin
               pr_d = pr_sub;
               dq_d = {dq_q[30:0], 1'b1};
            end else begin
               pr_d = pr_sh;
               dq_d = {dq_q[30:0], 1'b0};
            end
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd0) state_d = S_FIX;
         end
         S_FIX: begin
            quot_d = (sign_a_q ^ sign_b_q) ? -dq_q : dq_q;
            rem_d  = sign_a_q ? -pr_q[15:0] : pr_q[15:0];
            dbz_d  = 1'b0;
            ovf_d  = 1'b0;
            if (dbz_pend_q) begin
               quot_d = sign_a_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
               rem_d  = lo_q;
               dbz_d  = 1'b1;
            end else if (ovf_pend_q) begin
               quot_d = 32'h7FFF_FFFF;
               rem_d  = 16'h0000;
               ovf_d  = 1'b1;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         dq_q        <= '0;
         dv_q        <= '0;
         pr_q        <= '0;
         cnt_q       <= '0;
         sign_a_q    <= 1'b0;
         sign_b_q    <= 1'b0;
         dbz_pend_q  <= 1'b0;
         ovf_pend_q  <= 1'b0;
         lo_q        <= '0;
         quot_q      <= '0;
         rem_q       <= '0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         dq_q        <= dq_d;
         dv_q        <= dv_d;
         pr_q        <= pr_d;
         cnt_q       <= cnt_d;
         sign_a_q    <= sign_a_d;
         sign_b_q    <= sign_b_d;
         dbz_pend_q  <= dbz_pend_d;
         ovf_pend_q  <= ovf_pend_d;
         lo_q        <= lo_d;
         quot_q      <= quot_d;
         rem_q       <= rem_d;
         dbz_q       <= dbz_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_signed_divider_32by16.sv
// -----------------------------------------------------------------------------
// tb_signed_divider_32by16
//   Self-checking bench: constant vector table, reset / back-pressure / mid-op
//   reset sequences, then random operands against a truncating reference.
// -----------------------------------------------------------------------------
module tb_signed_divider_32by16;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] dividend;
   logic [15:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;
   logic        overflow;

   signed_divider_32by16 dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] a;
      logic [15:0] b;
      logic [31:0] q;
      logic [15:0] r;
      logic        dbz;
      logic        ovf;
   } vec_t;

   vec_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Truncating reference using 64-bit signed arithmetic.
   function automatic vec_t model(input logic [31:0] a, input logic [15:0] b);
      vec_t   m;
      longint sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      m.a = a; m.b = b; m.dbz = 1'b0; m.ovf = 1'b0;
      if (b == 16'h0000) begin
         m.q = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
         m.r = a[15:0];
         m.dbz = 1'b1;
      end else if (a == 32'h8000_0000 && b == 16'hFFFF) begin
         m.q = 32'h7FFF_FFFF;
         m.r = 16'h0000;
         m.ovf = 1'b1;
      end else begin
         q = sa / sb;
         r = sa % sb;
         m.q = q[31:0];
         m.r = r[15:0];
      end
      return m;
   endfunction

   // One full operation: accept, latency check, optional stall with ignored
   // in_valid pulses, scoreboard compare, retirement check.
   task automatic run_op(input vec_t e, input int stall);
      vec_t        got;
      int          t, acc, bad;
      logic [31:0] sq;
      logic [15:0] sr;
      logic        sd, so;
      t = 0;
      while (!in_ready && t < 100) begin @(negedge clk); t++; end
      chk("in_ready_before_op", in_ready, 1);
      sb_q.push_back(e);
      dividend = e.a; divisor = e.b; in_valid = 1'b1;
      @(negedge clk);
      acc = cyc;
      in_valid = 1'b0;
      dividend = $urandom;
      divisor  = 16'($urandom);
      t = 0;
      while (!out_valid && t < 100) begin @(negedge clk); t++; end
      chk("latency", 64'(cyc - acc), 33);
      sq = quotient; sr = remainder; sd = div_by_zero; so = overflow;
      bad = 0;
      for (int i = 0; i < stall; i++) begin
         in_valid = (i % 3 == 1);
         @(negedge clk);
         if (quotient !== sq || remainder !== sr || div_by_zero !== sd ||
             overflow !== so || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      end
      in_valid = 1'b0;
      if (stall > 0) chk("hold_under_backpressure", 64'(bad), 0);
      out_ready = 1'b1;
      if (sb_q.size() == 0) begin
         chk("scoreboard_nonempty", 0, 1);
      end else begin
         got = sb_q.pop_front();
         chk("quotient",    quotient,    got.q);
         chk("remainder",   remainder,   got.r);
         chk("div_by_zero", div_by_zero, got.dbz);
         chk("overflow",    overflow,    got.ovf);
      end
      @(negedge clk);
      out_ready = 1'b0;
      chk("retire_state", {out_valid, in_ready}, 2'b01);
   endtask

   vec_t tbl[12];

   initial begin
      vec_t e;
      int   seen;
      logic [31:0] ra;
      logic [15:0] rb;
      int   mode;

      tbl[0]  = '{32'd100000,      16'd7,      32'h0000_37CD, 16'h0005, 1'b0, 1'b0};
      tbl[1]  = '{-32'sd100000,    16'd7,      32'hFFFF_C833, 16'hFFFB, 1'b0, 1'b0};
      tbl[2]  = '{32'h7FFF_FFFF,   16'h8000,   32'hFFFF_0001, 16'h7FFF, 1'b0, 1'b0};
      tbl[3]  = '{32'd1234,        16'h0000,   32'h7FFF_FFFF, 16'h04D2, 1'b1, 1'b0};
      tbl[4]  = '{-32'sd5,         16'h0000,   32'h8000_0000, 16'hFFFB, 1'b1, 1'b0};
      tbl[5]  = '{32'h8000_0000,   16'hFFFF,   32'h7FFF_FFFF, 16'h0000, 1'b0, 1'b1};
      tbl[6]  = '{32'h8000_0000,   16'h8000,   32'h0001_0000, 16'h0000, 1'b0, 1'b0};
      tbl[7]  = '{-32'sd7,         16'hFFFE,   32'h0000_0003, 16'hFFFF, 1'b0, 1'b0};
      tbl[8]  = '{32'd5,           16'hFFF9,   32'h0000_0000, 16'h0005, 1'b0, 1'b0};
      tbl[9]  = '{32'h8000_0000,   16'h0001,   32'h8000_0000, 16'h0000, 1'b0, 1'b0};
      tbl[10] = '{32'd0,           16'd5,      32'h0000_0000, 16'h0000, 1'b0, 1'b0};
      tbl[11] = '{32'h8000_0000,   16'h0000,   32'h8000_0000, 16'h0000, 1'b1, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      dividend = '0; divisor = '0;
      repeat (2) @(negedge clk);
      chk("reset_in_ready",  in_ready,    1);
      chk("reset_out_valid", out_valid,   0);
      chk("reset_quotient",  quotient,    0);
      chk("reset_remainder", remainder,   0);
      chk("reset_flags",     {div_by_zero, overflow}, 2'b00);
      rst = 1'b0;
      @(negedge clk);

      // Constant vectors; odd entries stall a little.
      for (int i = 0; i < 12; i++) run_op(tbl[i], (i % 2) * 2);

      // Back-pressure: 10 stalled cycles with ignored in_valid pulses.
      run_op(tbl[1], 10);
      @(negedge clk);
      chk("no_accept_during_stall", in_ready, 1);

      // Reset 10 cycles after accept discards the operation.
      dividend = 32'd100000; divisor = 16'd7; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_in_ready",  in_ready,  1);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_quotient",  quotient,  0);
      chk("midrst_remainder", remainder, 0);
      chk("midrst_flags",     {div_by_zero, overflow}, 2'b00);
      seen = 0;
      repeat (40) begin @(negedge clk); if (out_valid) seen++; end
      chk("midrst_no_out_valid", 64'(seen), 0);
      run_op(tbl[0], 0);

      // Randomised operands with random stalls.
      for (int n = 0; n < 1000; n++) begin
         mode = $urandom_range(0, 9);
         ra = $urandom;
         rb = 16'($urandom);
         case (mode)
            0: rb = 16'h0000;
            1: begin ra = 32'h8000_0000; rb = 16'hFFFF; end
            2: rb = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(1, 16))
                                               : -16'($urandom_range(1, 16));
            3: ra = 32'($signed(16'($urandom)));
            4: rb = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
            default: ;
         endcase
         e = model(ra, rb);
         run_op(e, $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
